// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state type for the UART echo block
package uart_pkg;
  localparam int CLK_DIV_DEFAULT = 5000;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver behind a 2-flop synchronizer; UART_FRAME_CHECK_EN drops frames with a low stop bit
module uart_rx import uart_pkg::*; #(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int HALF_DIV = CLK_DIV / 2
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_byte
);
  localparam int CW = $clog2(CLK_DIV);
  uart_state_t state;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic rx_s, tick;
  assign rx_s = sync[1];
  assign tick = cnt == '0;
  always_ff @(posedge clk or posedge res)
    if (res) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      rx_valid <= 1'b0;
      cnt <= tick ? CW'(CLK_DIV - 1) : cnt - 1'b1;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          cnt <= CW'(HALF_DIV - 1);
        end
        START: if (tick) begin
          state <= rx_s ? IDLE : DATA;
          bit_idx <= '0;
        end
        DATA: if (tick) begin
          rx_byte <= {rx_s, rx_byte[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1)) state <= STOP;
        end
        STOP: if (tick) begin
`ifdef UART_FRAME_CHECK_EN
          rx_valid <= rx_s;
          state <= rx_s ? IDLE : BREAK;
`else
          rx_valid <= 1'b1;
          state <= IDLE;
`endif
        end
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/uart_echo_top.sv
// uart_echo_top: retransmits every received 8N1 byte through a one-byte newest-wins holding register
module uart_echo_top import uart_pkg::*; #(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int HALF_DIV = CLK_DIV / 2
) (
  input  logic clk,
  input  logic res,
  input  logic RX,
  output logic TX
);
  localparam int CW = $clog2(CLK_DIV);
  uart_state_t state;
  logic rx_valid, full, load, tick;
  logic [DATA_BITS-1:0] rx_byte, hold, shreg;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  uart_rx #(.CLK_DIV(CLK_DIV), .HALF_DIV(HALF_DIV)) u_rx (
    .clk(clk),
    .res(res),
    .rx(RX),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte)
  );
  assign load = state == IDLE && full;
  assign tick = cnt == '0;
  // a write in the same cycle as a load keeps full set for the new byte
  always_ff @(posedge clk or posedge res)
    if (res) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      hold <= '0;
      shreg <= '0;
      full <= 1'b0;
      TX <= 1'b1;
    end else begin
      if (rx_valid) hold <= rx_byte;
      full <= rx_valid | (full & ~load);
      cnt <= tick ? CW'(CLK_DIV - 1) : cnt - 1'b1;
      case (state)
        IDLE: if (full) begin
          shreg <= hold;
          TX <= 1'b0;
          cnt <= CW'(CLK_DIV - 1);
          state <= START;
        end
        START: if (tick) begin
          TX <= shreg[0];
          shreg <= shreg >> 1;
          bit_idx <= '0;
          state <= DATA;
        end
        DATA: if (tick) begin
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            TX <= 1'b1;
            state <= STOP;
          end else begin
            TX <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        STOP: if (tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_echo_top.sv
// tb_uart_echo_top: vector table plus scoreboard of bytes expected back on TX
module tb_uart_echo_top;
  localparam int D = 16;
  localparam int H = D / 2;
`ifdef UART_FRAME_CHECK_EN
  localparam logic FC = 1'b1;
`else
  localparam logic FC = 1'b0;
`endif
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       echo;
  } vec_t;

  logic clk = 1'b0, res = 1'b1, RX = 1'b1, TX;
  int checks = 0, errors = 0, frames = 0, cyc = 0, last_fall = 0, t_start = 0;
  logic mon_busy = 1'b0;
  logic [7:0] q[$];
  logic [7:0] m_got, m_exp;
  logic m_abort, m_have, m_start, m_stop;
  vec_t vecs[6];
  logic [7:0] pat[3];

  uart_echo_top #(.CLK_DIV(D), .HALF_DIV(H)) dut (.clk(clk), .res(res), .RX(RX), .TX(TX));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    t_start = cyc;
    RX = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (D) @(negedge clk);
    end
    RX = stop;
    repeat (D) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || mon_busy) && n < 30 * D) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", q.size() + int'(mon_busy), 0);
  endtask

  // TX monitor: samples each bit at its middle, pops the expected byte at the start bit
  initial forever begin
    @(negedge clk);
    if (!res && TX === 1'b0) begin
      mon_busy = 1'b1;
      last_fall = cyc;
      m_abort = 1'b0;
      m_have = q.size() != 0;
      m_exp = 8'h00;
      if (m_have) m_exp = q.pop_front();
      repeat (H) begin @(negedge clk); m_abort |= res; end
      m_start = TX;
      for (int i = 0; i < 8; i++) begin
        repeat (D) begin @(negedge clk); m_abort |= res; end
        m_got[i] = TX;
      end
      repeat (D) begin @(negedge clk); m_abort |= res; end
      m_stop = TX;
      if (!m_abort) begin
        if (!m_have) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %02h expected none", m_got);
        end else check("echo_byte", m_got, m_exp);
        check("start_bit", m_start, 0);
        check("stop_bit", m_stop, 1);
        frames++;
      end
      mon_busy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int bad, f0, lf0, lat, n;
    vecs[0] = '{8'h0A, 1'b1, 1'b1};
    vecs[1] = '{8'hFF, 1'b1, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'hA5, 1'b0, !FC};
    vecs[4] = '{8'h11, 1'b1, 1'b1};
    vecs[5] = '{8'hC3, 1'b1, 1'b1};
    pat = '{8'h0A, 8'h06, 8'h09};
    repeat (2) @(posedge clk);
    #1 check("reset_tx", TX, 1);
    @(negedge clk) res = 1'b0;
    bad = 0;
    repeat (500) begin @(negedge clk); if (TX !== 1'b1) bad++; end
    check("idle_tx_high", bad, 0);
    repeat (16 * D) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      f0 = frames;
      if (vecs[v].echo) q.push_back(vecs[v].data);
      send(vecs[v].data, vecs[v].stop);
      drain();
      repeat (3 * D) @(negedge clk);
      check("frame_count", frames - f0, 32'(vecs[v].echo));
      if (vecs[v].echo) begin
        lat = last_fall - t_start;
        checks++;
        if (lat < 9 * D + H + 3 || lat > 9 * D + H + 7) begin
          errors++;
          $display("FAIL latency: got %0d cycles expected %0d..%0d", lat, 9 * D + H + 3, 9 * D + H + 7);
        end
      end
    end

    f0 = frames;
    for (int i = 0; i < 12; i++) begin
      q.push_back(pat[i % 3]);
      send(pat[i % 3], 1'b1);
    end
    drain();
    check("b2b_frames", frames - f0, 12);

    f0 = frames;
    lf0 = last_fall;
    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (20 * D) @(negedge clk);
    check("glitch_frames", frames, f0);
    check("glitch_no_fall", last_fall, lf0);

    f0 = frames;
    q.push_back(8'h55);
    send(8'h55, 1'b1);
    n = 0;
    while (!mon_busy && n < 20 * D) begin @(negedge clk); n++; end
    check("reset_mid_started", mon_busy, 1);
    repeat (3 * D) @(negedge clk);
    res = 1'b1;
    #1 check("reset_mid_tx", TX, 1);
    @(negedge clk);
    @(negedge clk) res = 1'b0;
    repeat (12 * D) @(negedge clk);
    check("reset_mid_no_frame", frames, f0);
    check("reset_mid_tx_idle", TX, 1);
    q.push_back(8'h3C);
    send(8'h3C, 1'b1);
    drain();
    check("reset_mid_echo", frames - f0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
